// File: rtl/uart_loader.sv
// uart_loader: parses framed boot packets from a byte stream and writes packed 32-bit words
// to RAM, holding the CPU in reset until a load completes. Checksum byte: UART_LOADER_CKSUM_EN.
module uart_loader #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        rx_frame_error,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);
    typedef enum logic [2:0] {
        StIdle, StAddr, StLen, StData, StWrite, StCksum, StFinish
    } state_e;

`ifdef UART_LOADER_CKSUM_EN
    localparam state_e AfterData  = StCksum;
    localparam logic   AfterReady = 1'b1;
`else
    localparam state_e AfterData  = StFinish;
    localparam logic   AfterReady = 1'b0;
`endif

    state_e      state_q;
    logic [1:0]  byte_cnt_q;
    logic [15:0] remaining_q;
    logic [31:0] tmo_q;
    logic        accept;
    logic        collecting;
    logic        timeout_hit;

    assign accept      = s_axis_tvalid && s_axis_tready;
    assign collecting  = state_q inside {StAddr, StLen, StData, StCksum};
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && collecting && !accept &&
                         (tmo_q >= TIMEOUT_CYCLES - 1);

`ifdef UART_LOADER_CKSUM_EN
    logic [7:0] cksum_q;
    logic [7:0] cksum_next;
    assign cksum_next = cksum_q + s_axis_tdata;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            byte_cnt_q    <= '0;
            remaining_q   <= '0;
            tmo_q         <= '0;
            s_axis_tready <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_we        <= 1'b0;
            cpu_hold      <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
`ifdef UART_LOADER_CKSUM_EN
            cksum_q       <= '0;
`endif
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (state_q != StIdle && (rx_frame_error || timeout_hit)) begin
                // Abort wins over a byte accepted in the same cycle.
                state_q       <= StIdle;
                mem_we        <= 1'b0;
                s_axis_tready <= 1'b1;
                error         <= 1'b1;
            end else begin
                if (accept) begin
                    tmo_q      <= '0;
                    byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef UART_LOADER_CKSUM_EN
                    cksum_q    <= cksum_next;
`endif
                end else if (collecting) begin
                    tmo_q <= tmo_q + 32'd1;
                end

                unique case (state_q)
                    StIdle: begin
                        s_axis_tready <= 1'b1;
                        byte_cnt_q    <= '0;
                        if (accept && s_axis_tdata == SYNC_BYTE) begin
                            state_q  <= StAddr;
                            cpu_hold <= 1'b1;
`ifdef UART_LOADER_CKSUM_EN
                            cksum_q  <= '0;
`endif
                        end
                    end
                    StAddr: begin
                        if (accept) begin
                            mem_addr[{byte_cnt_q, 3'b000} +: 8] <=
                                (byte_cnt_q == 2'd0) ? {s_axis_tdata[7:2], 2'b00} : s_axis_tdata;
                            if (byte_cnt_q == 2'd3) state_q <= StLen;
                        end
                    end
                    StLen: begin
                        if (accept) begin
                            remaining_q[{byte_cnt_q[0], 3'b000} +: 8] <= s_axis_tdata;
                            if (byte_cnt_q[0]) begin
                                byte_cnt_q <= '0;
                                if ({s_axis_tdata, remaining_q[7:0]} == 16'd0) begin
                                    state_q       <= AfterData;
                                    s_axis_tready <= AfterReady;
                                end else begin
                                    state_q <= StData;
                                end
                            end
                        end
                    end
                    StData: begin
                        if (accept) begin
                            mem_wdata[{byte_cnt_q, 3'b000} +: 8] <= s_axis_tdata;
                            if (byte_cnt_q == 2'd3) begin
                                state_q       <= StWrite;
                                mem_we        <= 1'b1;
                                s_axis_tready <= 1'b0;
                            end
                        end
                    end
                    StWrite: begin
                        if (mem_ready) begin
                            mem_we      <= 1'b0;
                            mem_addr    <= mem_addr + 32'd4;
                            remaining_q <= remaining_q - 16'd1;
                            tmo_q       <= '0;
                            if (remaining_q == 16'd1) begin
                                state_q       <= AfterData;
                                s_axis_tready <= AfterReady;
                            end else begin
                                state_q       <= StData;
                                s_axis_tready <= 1'b1;
                            end
                        end
                    end
`ifdef UART_LOADER_CKSUM_EN
                    StCksum: begin
                        if (accept) begin
                            if (cksum_next == 8'h00) begin
                                state_q       <= StFinish;
                                s_axis_tready <= 1'b0;
                            end else begin
                                state_q <= StIdle;
                                error   <= 1'b1;
                            end
                        end
                    end
`endif
                    StFinish: begin
                        state_q       <= StIdle;
                        s_axis_tready <= 1'b1;
                        done          <= 1'b1;
                        cpu_hold      <= 1'b0;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: packet model builds bytes and expected writes,
// a negedge monitor scores every write and pulse against it.
module tb_uart_loader;
    localparam int unsigned Tmo = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        rx_frame_error;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_ready;
    logic        cpu_hold;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    uart_loader #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (Tmo)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .rx_frame_error (rx_frame_error),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_we         (mem_we),
        .mem_ready      (mem_ready),
        .cpu_hold       (cpu_hold),
        .done           (done),
        .error          (error)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int wr_cnt   = 0;
    int ready_lat = 0;
    int wait_cnt  = 0;
    logic [31:0] last_addr, last_data;
    logic [7:0]  last_ck;
    logic [63:0] exp_wr[$];
    logic [7:0]  pkt[$];
    logic [31:0] words[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory side: hold mem_ready low ready_lat cycles after a request appears.
    always @(posedge clk) begin
        #1;
        if (mem_we && !mem_ready) begin
            if (wait_cnt >= ready_lat) mem_ready = 1'b1;
            else wait_cnt++;
        end else begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
        end
    end

    // Compare process: writes against the model queue, plus per-cycle protocol rules.
    logic        prev_we, prev_ready;
    logic [31:0] prev_addr, prev_data;
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we && mem_ready) begin
                check("write expected", (exp_wr.size() != 0) ? 32'd1 : 32'd0, 32'd1);
                if (exp_wr.size() != 0) begin
                    check("write addr", mem_addr, exp_wr[0][63:32]);
                    check("write data", mem_wdata, exp_wr[0][31:0]);
                    void'(exp_wr.pop_front());
                end
                last_addr <= mem_addr;
                last_data <= mem_wdata;
                wr_cnt++;
            end
            if (mem_we) check("tready low in write", {31'd0, s_axis_tready}, 32'd0);
            check("addr aligned", {30'd0, mem_addr[1:0]}, 32'd0);
            check("done/error exclusive", {31'd0, done && error}, 32'd0);
            if (prev_we && !prev_ready) begin
                check("we held", {31'd0, mem_we}, 32'd1);
                check("addr held", mem_addr, prev_addr);
                check("data held", mem_wdata, prev_data);
            end
            if (done) done_cnt++;
            if (error) err_cnt++;
        end
        prev_we    <= mem_we;
        prev_ready <= mem_ready;
        prev_addr  <= mem_addr;
        prev_data  <= mem_wdata;
    end

    // Model: serialise a packet from (addr, words) and queue the writes it must cause.
    task automatic build(input logic [31:0] addr, input bit bad_ck);
        logic [7:0]  s;
        logic [15:0] len;
        logic [31:0] a;
        logic [31:0] w;
        pkt.delete();
        pkt.push_back(8'hA5);
        for (int i = 0; i < 4; i++) pkt.push_back(addr[8*i +: 8]);
        len = 16'(words.size());
        pkt.push_back(len[7:0]);
        pkt.push_back(len[15:8]);
        for (int i = 0; i < words.size(); i++) begin
            w = words[i];
            for (int j = 0; j < 4; j++) pkt.push_back(w[8*j +: 8]);
            a = {addr[31:2], 2'b00} + 32'(4 * i);
            exp_wr.push_back({a, w});
        end
        s = 8'h00;
        for (int i = 1; i < pkt.size(); i++) s = s + pkt[i];
        last_ck = 8'h00 - s;
`ifdef UART_LOADER_CKSUM_EN
        pkt.push_back(bad_ck ? 8'h00 : last_ck);
`else
        if (bad_ck) pkt.push_back(8'h00);
`endif
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        k = 0;
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        forever begin
            @(posedge clk);
            if (s_axis_tready) break;
            k++;
            if (k > 200) begin
                check("tready wait bound", 32'd0, 32'd1);
                break;
            end
        end
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_outcome(input int d0, input int e0);
        int k;
        k = 0;
        while (done_cnt == d0 && err_cnt == e0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        check("outcome within bound", (k < 300) ? 32'd1 : 32'd0, 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_packet(input logic [31:0] addr, input bit bad_ck, input bit exp_done);
        int d0, e0, w0, nw;
        d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt; nw = words.size();
        build(addr, bad_ck);
        foreach (pkt[i]) send_byte(pkt[i]);
        wait_outcome(d0, e0);
        check("done pulses", 32'(done_cnt - d0), exp_done ? 32'd1 : 32'd0);
        check("error pulses", 32'(err_cnt - e0), exp_done ? 32'd0 : 32'd1);
        check("write count", 32'(wr_cnt - w0), 32'(nw));
        check("cpu_hold after", {31'd0, cpu_hold}, exp_done ? 32'd0 : 32'd1);
        check("writes drained", 32'(exp_wr.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: got no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int d0, e0, w0;
        rst = 1'b1;
        s_axis_tdata = 8'h00;
        s_axis_tvalid = 1'b0;
        rx_frame_error = 1'b0;
        mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("reset mem_we", {31'd0, mem_we}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset error", {31'd0, error}, 32'd0);
        check("reset tready", {31'd0, s_axis_tready}, 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("tready after reset", {31'd0, s_axis_tready}, 32'd1);

        // Basic two-word load, memory always ready.
        words = '{32'h44332211, 32'h88776655};
        run_packet(32'h0000_1000, 1'b0, 1'b1);
        check("last write addr", last_addr, 32'h0000_1004);
        check("last write data", last_data, 32'h8877_6655);
        check("model checksum", {24'd0, last_ck}, 32'h0000_008A);

        // Same packet with slow memory.
        ready_lat = 5;
        run_packet(32'h0000_1000, 1'b0, 1'b1);
        ready_lat = 0;

        // Unaligned start address and 32-bit wrap.
        words = '{32'hCAFEF00D, 32'h01234567};
        run_packet(32'hFFFF_FFFE, 1'b0, 1'b1);
        check("wrap last addr", last_addr, 32'h0000_0000);

`ifdef UART_LOADER_CKSUM_EN
        words = '{32'h44332211, 32'h88776655};
        run_packet(32'h0000_1000, 1'b1, 1'b0);
`endif

        // Frame error during ADDR; the concurrent byte is discarded.
        d0 = done_cnt; e0 = err_cnt; w0 = wr_cnt;
        send_byte(8'hA5);
        #1;
        send_byte(8'h00);
        send_byte(8'h10);
        rx_frame_error = 1'b1;
        s_axis_tdata   = 8'h00;
        s_axis_tvalid  = 1'b1;
        @(posedge clk);
        #1;
        rx_frame_error = 1'b0;
        s_axis_tvalid  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("frame err pulse", 32'(err_cnt - e0), 32'd1);
        check("frame err no done", 32'(done_cnt - d0), 32'd0);
        check("frame err cpu_hold", {31'd0, cpu_hold}, 32'd1);

        // Timeout mid-DATA: 10 idle cycles tolerated, 20 must abort.
        e0 = err_cnt;
        send_byte(8'hA5);
        send_byte(8'h00); send_byte(8'h20); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'hEF); send_byte(8'hBE);
        repeat (10) @(posedge clk);
        #1;
        check("no early timeout", 32'(err_cnt - e0), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("timeout pulse", 32'(err_cnt - e0), 32'd1);
        check("timeout no write", 32'(wr_cnt - w0), 32'd0);

        // Junk before SYNC, then an empty packet.
        send_byte(8'h00);
        send_byte(8'hFF);
        words.delete();
        run_packet(32'h0000_0000, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
